// File: rtl/cr_wr_arb_pkg.sv
// cr_wr_arb_pkg: CR geometry constants and field-mask to bit-mask expansion
package cr_wr_arb_pkg;
  localparam int CR_WIDTH = 32;
  localparam int CR_NFIELD = CR_WIDTH / 4;
  function automatic logic [CR_WIDTH-1:0] fmask_to_bmask(input logic [CR_NFIELD-1:0] m);
    for (int k = 0; k < CR_NFIELD; k++) fmask_to_bmask[4*k +: 4] = {4{m[k]}};
  endfunction
endpackage

// File: rtl/cr_rr_pick.sv
// cr_rr_pick: one-hot pick of the first valid requester scanning from rr_ptr
module cr_rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  primary
);
  logic [PW-1:0] idx;
  always_comb begin
    primary = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (valid[idx]) begin
        primary = '0;
        primary[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cr_wr_arb.sv
// cr_wr_arb: round-robin merge of CR field writes into a one-entry write buffer
module cr_wr_arb
  import cr_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CR_WIDTH = cr_wr_arb_pkg::CR_WIDTH,
  parameter int NFIELD = cr_wr_arb_pkg::CR_NFIELD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*NFIELD-1:0]   req_fmask,
  input  logic [NREQ*CR_WIDTH-1:0] req_data,
  input  logic                     cr_hold,
  input  logic                     flush,
  input  logic [CR_WIDTH-1:0]      cr_rd,
  output logic                     cr_wr,
  output logic [CR_WIDTH-1:0]      cr_wd,
  output logic [NFIELD-1:0]        pend_fmask
);
  localparam int PW = $clog2(NREQ);
  logic                hold_v_q, hold_v_d;
  logic [NFIELD-1:0]   hold_mask_q, hold_mask_d, gmask, fm;
  logic [CR_WIDTH-1:0] hold_data_q, hold_data_d, gdata, bm;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d, prim_idx, idx;
  logic [NREQ-1:0]     primary, gnt;
  logic                can_accept, drain;
  cr_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .primary(primary)
  );
  always_comb begin
    can_accept = !rst && !flush && (!hold_v_q || !cr_hold);
    drain = !rst && hold_v_q && !cr_hold && !flush;
    bm = fmask_to_bmask(hold_mask_q);
    cr_wr = drain && |hold_mask_q;
    cr_wd = (cr_rd & ~bm) | (hold_data_q & bm);
    pend_fmask = (hold_v_q && !rst) ? hold_mask_q : '0;
    gnt = '0;
    gmask = '0;
    gdata = '0;
    idx = '0;
    fm = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      fm = req_fmask[idx*NFIELD +: NFIELD];
      if (can_accept && req_valid[idx] && (primary[idx] || (fm & gmask) == '0)) begin
        gnt[idx] = 1'b1;
        gmask = gmask | fm;
        gdata = gdata | (req_data[idx*CR_WIDTH +: CR_WIDTH] & fmask_to_bmask(fm));
      end
    end
    prim_idx = '0;
    for (int i = 0; i < NREQ; i++) if (primary[i]) prim_idx = PW'(i);
    req_ready = gnt;
    rr_ptr_d = |gnt ? PW'((int'(prim_idx) + 1) % NREQ) : rr_ptr_q;
    hold_v_d = flush ? 1'b0 : |gnt ? 1'b1 : drain ? 1'b0 : hold_v_q;
    hold_mask_d = flush ? '0 : |gnt ? gmask : hold_mask_q;
    hold_data_d = |gnt ? gdata : hold_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_mask_q <= '0;
      hold_data_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_mask_q <= hold_mask_d;
      hold_data_q <= hold_data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_cr_wr_arb.sv
// tb_cr_wr_arb: directed and randomized checks of cr_wr_arb against a field-level model
module tb_cr_wr_arb;
  logic clk = 1'b0;
  logic rst, cr_hold, flush, cr_wr;
  logic [3:0] req_valid, req_ready;
  logic [7:0] fm [4];
  logic [31:0] dt [4];
  logic [31:0] req_fmask;
  logic [127:0] req_data;
  logic [31:0] cr_rd, cr_wd;
  logic [7:0] pend_fmask;
  int errors = 0;
  int checks = 0;
  assign req_fmask = {fm[3], fm[2], fm[1], fm[0]};
  assign req_data = {dt[3], dt[2], dt[1], dt[0]};
  always #5 clk = ~clk;
  cr_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmask (req_fmask),
    .req_data  (req_data),
    .cr_hold   (cr_hold),
    .flush     (flush),
    .cr_rd     (cr_rd),
    .cr_wr     (cr_wr),
    .cr_wd     (cr_wd),
    .pend_fmask(pend_fmask)
  );
  bit m_hv, n_hv;
  logic [7:0] m_mask, n_mask;
  logic [31:0] m_data, n_data;
  int m_rr, n_rr;
  logic [3:0] e_ready;
  logic e_wr;
  logic [31:0] e_wd;
  logic [7:0] e_pend;
  function automatic logic [31:0] nib_merge(input logic [7:0] mask, input logic [31:0] nv, input logic [31:0] ov);
    logic [31:0] r;
    for (int f = 0; f < 8; f++) r[31-4*f -: 4] = mask[7-f] ? nv[31-4*f -: 4] : ov[31-4*f -: 4];
    return r;
  endfunction
  task automatic model_eval();
    bit can;
    logic [7:0] u;
    int first, i;
    can = !rst && !flush && (!m_hv || !cr_hold);
    e_ready = 4'b0;
    u = 8'h00;
    first = -1;
    n_data = 32'h0;
    if (can)
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (req_valid[i] && (first < 0 || (fm[i] & u) == 8'h00)) begin
          e_ready[i] = 1'b1;
          if (first < 0) first = i;
          u = u | fm[i];
          n_data = n_data | nib_merge(fm[i], dt[i], 32'h0);
        end
      end
    e_wr = !rst && m_hv && !cr_hold && !flush && m_mask != 8'h00;
    e_wd = nib_merge(m_mask, m_data, cr_rd);
    e_pend = (!rst && m_hv) ? m_mask : 8'h00;
    if (rst) begin
      n_hv = 0; n_mask = 8'h00; n_data = 32'h0; n_rr = 0;
    end else if (flush) begin
      n_hv = 0; n_mask = 8'h00; n_data = m_data; n_rr = m_rr;
    end else if (first >= 0) begin
      n_hv = 1; n_mask = u; n_rr = (first + 1) % 4;
    end else begin
      n_hv = m_hv && cr_hold; n_mask = m_mask; n_data = m_data; n_rr = m_rr;
    end
  endtask
  task automatic tick();
    model_eval();
    @(posedge clk);
    m_hv = n_hv; m_mask = n_mask; m_data = n_data; m_rr = n_rr;
    #1;
  endtask
  task automatic idle(input int n);
    req_valid = 4'b0; flush = 0; cr_hold = 0;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    rst = 1; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin fm[i] = 8'hFF; dt[i] = $urandom; end
    repeat (2) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      checks++; if (cr_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", cr_wr); end
      checks++; if (pend_fmask !== 8'h00) begin errors++; $display("FAIL reset_pend got=%h exp=00", pend_fmask); end
      tick();
    end
    rst = 0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
    idle(2);
  endtask
  task automatic test_single();
    cr_rd = 32'h0; fm[0] = 8'h80; dt[0] = 32'hA000_0000; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0;
    #1;
    checks++; if (cr_wr !== 1'b1) begin errors++; $display("FAIL single_wr got=%b exp=1", cr_wr); end
    checks++; if (cr_wd !== 32'hA000_0000) begin errors++; $display("FAIL single_wd got=%h exp=a0000000", cr_wd); end
    checks++; if (pend_fmask !== 8'h80) begin errors++; $display("FAIL single_pend got=%h exp=80", pend_fmask); end
    tick();
    #1;
    checks++; if (cr_wr !== 1'b0 || pend_fmask !== 8'h00) begin errors++; $display("FAIL single_retire got=%b/%h exp=0/00", cr_wr, pend_fmask); end
  endtask
  task automatic test_conflict();
    rst = 1; tick(); rst = 0;
    cr_rd = 32'h0;
    fm[0] = 8'h80; dt[0] = 32'h1000_0000; fm[1] = 8'h80; dt[1] = 32'h2000_0000;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL conflict_first got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conflict_second got=%b exp=0010", req_ready); end
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h1000_0000) begin errors++; $display("FAIL conflict_wr0 got=%b/%h exp=1/10000000", cr_wr, cr_wd); end
    tick();
    fm[3] = 8'h80; dt[3] = 32'h3000_0000; req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL conflict_rr2 got=%b exp=1000", req_ready); end
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h2000_0000) begin errors++; $display("FAIL conflict_wr1 got=%b/%h exp=1/20000000", cr_wr, cr_wd); end
    tick();
    req_valid = 4'b0;
    #1;
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h3000_0000) begin errors++; $display("FAIL conflict_wr3 got=%b/%h exp=1/30000000", cr_wr, cr_wd); end
    tick();
  endtask
  task automatic test_merge();
    cr_rd = 32'hFFFF_FFFF;
    fm[1] = 8'h01; dt[1] = 32'h0000_0005; fm[2] = 8'h40; dt[2] = 32'h0300_0000;
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL merge_ready got=%b exp=0110", req_ready); end
    tick();
    req_valid = 4'b0;
    #1;
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'hF3FF_FFF5) begin errors++; $display("FAIL merge_wd got=%b/%h exp=1/f3fffff5", cr_wr, cr_wd); end
    checks++; if (pend_fmask !== 8'h41) begin errors++; $display("FAIL merge_pend got=%h exp=41", pend_fmask); end
    tick();
  endtask
  task automatic test_hold();
    cr_rd = 32'h0; cr_hold = 1;
    fm[0] = 8'h10; dt[0] = 32'h0007_0000; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_empty_capture got=%b exp=0001", req_ready); end
    tick();
    fm[1] = 8'h02; dt[1] = 32'h0000_0030; req_valid = 4'b0010;
    repeat (3) begin
      #1;
      checks++; if (cr_wr !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL hold_stall got=%b/%b exp=0/0000", cr_wr, req_ready); end
      checks++; if (pend_fmask !== 8'h10) begin errors++; $display("FAIL hold_pend got=%h exp=10", pend_fmask); end
      tick();
    end
    cr_hold = 0;
    #1;
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h0007_0000) begin errors++; $display("FAIL hold_release got=%b/%h exp=1/00070000", cr_wr, cr_wd); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_next_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0;
    #1;
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h0000_0030) begin errors++; $display("FAIL hold_second_wr got=%b/%h exp=1/00000030", cr_wr, cr_wd); end
    tick();
  endtask
  task automatic test_flush();
    cr_rd = 32'h0; fm[0] = 8'h08; dt[0] = 32'h0000_9000; req_valid = 4'b0001;
    tick();
    fm[3] = 8'h04; dt[3] = 32'h0000_0B00; req_valid = 4'b1000; flush = 1;
    #1;
    checks++; if (cr_wr !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL flush_block got=%b/%b exp=0/0000", cr_wr, req_ready); end
    checks++; if (pend_fmask !== 8'h08) begin errors++; $display("FAIL flush_pend_before got=%h exp=08", pend_fmask); end
    tick();
    flush = 0;
    #1;
    checks++; if (pend_fmask !== 8'h00 || cr_wr !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%h/%b exp=00/0", pend_fmask, cr_wr); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_regrant got=%b exp=1000", req_ready); end
    tick();
    req_valid = 4'b0;
    #1;
    checks++; if (cr_wr !== 1'b1 || cr_wd !== 32'h0000_0B00) begin errors++; $display("FAIL flush_after_wr got=%b/%h exp=1/00000b00", cr_wr, cr_wd); end
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cr_hold = ($urandom_range(0, 3) == 0);
      cr_rd = $urandom;
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          case ($urandom_range(0, 3))
            0: fm[i] = 8'h00;
            2: fm[i] = 8'($urandom);
            default: fm[i] = 8'h01 << $urandom_range(0, 7);
          endcase
          dt[i] = $urandom;
        end
      #1;
      model_eval();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, e_ready); end
      checks++; if (cr_wr !== e_wr) begin errors++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", c, cr_wr, e_wr); end
      checks++; if (pend_fmask !== e_pend) begin errors++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pend_fmask, e_pend); end
      if (e_wr) begin
        checks++; if (cr_wd !== e_wd) begin errors++; $display("FAIL rnd_wd cyc=%0d got=%h exp=%h", c, cr_wd, e_wd); end
      end
      tick();
      req_valid = req_valid & ~e_ready;
    end
    rst = 0;
    idle(2);
  endtask
  initial begin
    rst = 1; cr_hold = 0; flush = 0; cr_rd = 32'h0; req_valid = 4'b0;
    m_hv = 0; m_mask = 8'h00; m_data = 32'h0; m_rr = 0;
    for (int i = 0; i < 4; i++) begin fm[i] = 8'h00; dt[i] = 32'h0; end
    test_reset();
    test_single();
    test_conflict();
    test_merge();
    test_hold();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
